imm_encoder: RTL
================

# imm_encoder

Multi-cycle encoder that converts a 32-bit constant or byte offset into the 24-bit instruction immediate field the datapath's immediate extender decodes. It covers all three ImmSrc formats: data-processing rotated imm8, LDR/STR 12-bit offset, and branch 24-bit word offset. It sits in the instruction-generation and test infrastructure alongside the core. For data-processing it performs the full ARM rotate search, one rotation per cycle. Results with rot = 0 round-trip exactly through the existing extender.

## Interface
- No parameters.
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request strobe; accepted only when busy = 0.
- imm_src  in  2  format: 00 DP rotated imm8, 01 memory 12-bit, 10 branch, 11 invalid.
- value  in  32  constant (DP / memory) or signed byte offset (branch); latched on accept.
- busy  out  1  high from the cycle after accept until the cycle before done.
- done  out  1  one-cycle pulse; result valid.
- ok  out  1  1 = encodable; qualified by done, held afterwards.
- field  out  24  Instr[23:0] image; bits not used by the format are 0; all 0 when ok = 0.

## Operation
- FSM states: IDLE, SEARCH, FINISH.
- IDLE + start: latch value and imm_src. Go to SEARCH with rot counter = 0.
- SEARCH tests one candidate per cycle.
- imm_src 00: compute r = value ROL (2·rot).
  - If r[31:8] == 0: match, with field = {12'b0, rot[3:0], r[7:0]}.
  - If no match and rot == 15: fail.
  - Otherwise rot increments.
  - The smallest matching rot always wins.
- imm_src 01: match iff value[31:12] == 0; field = {12'b0, value[11:0]}. Decided in the first SEARCH cycle.
- imm_src 10: match iff value[1:0] == 0 and value[31:25] all equal value[25]; field = value[25:2]. Decided in the first SEARCH cycle.
- imm_src 11: fail in the first SEARCH cycle.
- Match or fail registers ok and field, then goes to FINISH.
- FINISH: done = 1, busy = 0, next state IDLE.
- start in FINISH is not accepted, because accept happens only in IDLE.
- start while busy = 1: ignored, with no effect on the in-flight operation.
- ok and field hold until the next accepted start. They are cleared to 0 on accept.

## Timing
- Reset values (async, immediate): state IDLE, busy 0, done 0, ok 0, field 0, rot 0.
- Start sampled high in IDLE at edge T.
- DP match at rotation r: done high in cycle T+2+r, so latency ranges from 2 to 17 cycles.
- DP fail: done high in cycle T+17, with ok = 0.
- Memory, branch and invalid formats: done high in cycle T+2.
- Earliest next accept: the cycle after done (IDLE), i.e. back-to-back throughput is one result per latency + 1 cycles.
- reset_n low mid-SEARCH: aborts immediately to reset values. No done pulse is produced for the aborted request.
- Rotate width rule: shift amount = {rot, 1'b0} mod 32, so rot 15 gives ROL 30.

## Structure
- Package imm_pkg holds:
  - the imm_src encodings IMM_DP = 2'b00, IMM_MEM = 2'b01, IMM_BR = 2'b10, shared with the extender;
  - the FSM state enum.
- Sub-module imm_rot_check: combinational. Inputs value[31:0] and rot[3:0]; outputs match and imm8[7:0].
- Everything else (FSM, counter, output registers) lives in imm_encoder.

## Test plan
- DP, value 0x000000AB, start at T: done in T+2, ok = 1, field = 0x0000AB. Then feeding field through the extender returns 0x000000AB.
- DP 0xFF000000: done in T+6, ok = 1, field = 0x0004FF (rot 4).
- DP 0xF000000F: done in T+4, ok = 1, field = 0x0002FF.
- DP 0x00000101: done in T+17, ok = 0, field = 0; busy high T+1..T+16.
- Memory 0x00000FFF: done in T+2, ok = 1, field = 0x000FFF. Memory 0x00001000: ok = 0.
- Branch 0xFFFFFFF8: field = 0xFFFFFE, ok = 1. Branch 0x00000006: ok = 0. Branch 0x02000000: ok = 0.
- DP 0x00000101 started; at T+5, start is raised with a new value, which is ignored. Result: done still at T+17 with ok = 0.
- A second DP run started; reset_n pulsed low at T+8: all outputs 0 at once, no done pulse. Next start completes normally.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared immediate-format encodings and encoder FSM states.
// The imm_src codes must stay in step with the datapath's immediate extender.
package imm_pkg;

  localparam logic [1:0] IMM_DP  = 2'b00;
  localparam logic [1:0] IMM_MEM = 2'b01;
  localparam logic [1:0] IMM_BR  = 2'b10;
  localparam logic [1:0] IMM_BAD = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_SEARCH = 2'b01,
    S_FINISH = 2'b10
  } imm_state_t;

endpackage

// File: rtl/imm_rot_check.sv
// Tests a single rotate candidate: value ROL (2*rot) must fit in eight bits.
module imm_rot_check (
  input  logic [31:0] value,
  input  logic [3:0]  rot,
  output logic        match,
  output logic [7:0]  imm8
);

  logic [4:0]  w_shamt;
  logic [63:0] w_dbl;
  logic [31:0] w_rol;

  assign w_shamt = {rot, 1'b0};
  // Upper half of the doubled word shifted left is the 32-bit rotate-left.
  assign w_dbl   = {value, value} << w_shamt;
  assign w_rol   = w_dbl[63:32];
  assign match   = (w_rol[31:8] == 24'd0);
  assign imm8    = w_rol[7:0];

endmodule

// File: rtl/imm_encoder.sv
// Encodes a constant or byte offset into the 24-bit instruction immediate field,
// searching data-processing rotations one candidate per cycle.
module imm_encoder
  import imm_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  imm_src,
  input  logic [31:0] value,
  output logic        busy,
  output logic        done,
  output logic        ok,
  output logic [23:0] field
);

  imm_state_t  r_state;
  logic [3:0]  r_rot;
  logic [1:0]  r_src;
  logic [31:0] r_value;
  logic        r_ok;
  logic [23:0] r_field;

  logic        w_match;
  logic [7:0]  w_imm8;
  logic        w_mem_ok;
  logic        w_br_ok;

  imm_rot_check u_rot_check (
    .value (r_value),
    .rot   (r_rot),
    .match (w_match),
    .imm8  (w_imm8)
  );

  assign w_mem_ok = (r_value[31:12] == 20'd0);
  // Branch offset must be word aligned and sign-extend cleanly from bit 25.
  assign w_br_ok  = (r_value[1:0] == 2'b00) &&
                    ((&r_value[31:25]) || !(|r_value[31:25]));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_rot   <= 4'd0;
      r_src   <= 2'b00;
      r_value <= 32'd0;
      r_ok    <= 1'b0;
      r_field <= 24'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_SEARCH;
            r_rot   <= 4'd0;
            r_src   <= imm_src;
            r_value <= value;
            r_ok    <= 1'b0;
            r_field <= 24'd0;
          end
        end
        S_SEARCH: begin
          case (r_src)
            IMM_DP: begin
              if (w_match) begin
                r_ok    <= 1'b1;
                r_field <= {12'd0, r_rot, w_imm8};
                r_state <= S_FINISH;
              end else if (r_rot == 4'd15) begin
                r_ok    <= 1'b0;
                r_field <= 24'd0;
                r_state <= S_FINISH;
              end else begin
                r_rot   <= r_rot + 4'd1;
              end
            end
            IMM_MEM: begin
              r_ok    <= w_mem_ok;
              r_field <= w_mem_ok ? {12'd0, r_value[11:0]} : 24'd0;
              r_state <= S_FINISH;
            end
            IMM_BR: begin
              r_ok    <= w_br_ok;
              r_field <= w_br_ok ? r_value[25:2] : 24'd0;
              r_state <= S_FINISH;
            end
            default: begin
              r_ok    <= 1'b0;
              r_field <= 24'd0;
              r_state <= S_FINISH;
            end
          endcase
        end
        S_FINISH: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  assign busy  = (r_state == S_SEARCH);
  assign done  = (r_state == S_FINISH);
  assign ok    = r_ok;
  assign field = r_field;

endmodule
